// File: rtl/conv_bn_relu_channel_out.sv
// Per-output-channel batch-norm (fixed-point scale and bias) followed by ReLU on a
// channel-major pixel stream; coefficients are loaded once after reset, then a 3-stage pipeline runs.
module conv_bn_relu_channel_out #(
   parameter int DATA_WIDTH      = 32,
   parameter int FRAC_BITS       = 16,
   parameter int IMAGE_WIDTH     = 32,
   parameter int IMAGE_HEIGHT    = 32,
   parameter int CHANNEL_NUM_OUT = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_weight_in,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   output logic                  coef_ready,
   output logic                  err_out
);

   localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int WORDS      = 2 * CHANNEL_NUM_OUT;
   localparam int WW         = $clog2(WORDS);
   localparam int PW         = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
   localparam int CW         = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
   localparam int PRODW      = 2 * DATA_WIDTH;

   localparam logic signed [PRODW-1:0] RND   = {{(PRODW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
   localparam logic signed [PRODW-1:0] MAX_L = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [PRODW-1:0] MIN_L = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0]   MAX_W = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0]   MIN_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {LOAD, RUN} state_t;

   state_t                   state;
   logic [WW-1:0]            word_cnt;
   logic [PW-1:0]            pix_cnt;
   logic [CW-1:0]            ch_cnt;
   logic [DATA_WIDTH-1:0]    scale_mem [CHANNEL_NUM_OUT];
   logic [DATA_WIDTH-1:0]    bias_mem  [CHANNEL_NUM_OUT];
   logic [CW-1:0]            coef_idx;
   logic                     accept;

   logic signed [PRODW-1:0]  px_ext;
   logic signed [PRODW-1:0]  sc_ext;
   logic [DATA_WIDTH-1:0]    sc_word;
   logic                     s1_valid;
   logic signed [PRODW-1:0]  s1_prod;
   logic [DATA_WIDTH-1:0]    s1_bias;
   logic signed [PRODW-1:0]  rounded;
   logic [DATA_WIDTH-1:0]    scaled;
   logic [DATA_WIDTH:0]      sum_ext;
   logic [DATA_WIDTH-1:0]    sat_sum;
   logic                     s2_valid;
   logic [DATA_WIDTH-1:0]    s2_sum;

   assign coef_idx = CW'(word_cnt >> 1);
   assign accept   = (state == RUN) && valid_in;

   // Coefficient words alternate scale/bias; contents survive reset but are reloaded anyway.
   always_ff @(posedge clk) begin
      if (state == LOAD && valid_weight_in) begin
         if (!word_cnt[0])
            scale_mem[coef_idx] <= weight_in;
         else
            bias_mem[coef_idx] <= weight_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= LOAD;
         word_cnt   <= '0;
         pix_cnt    <= '0;
         ch_cnt     <= '0;
         coef_ready <= 1'b0;
         err_out    <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (valid_in)
                  err_out <= 1'b1;
               if (valid_weight_in) begin
                  if (word_cnt == WW'(WORDS - 1)) begin
                     word_cnt   <= '0;
                     state      <= RUN;
                     coef_ready <= 1'b1;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (valid_in) begin
                  if (pix_cnt == PW'(IMAGE_SIZE - 1)) begin
                     pix_cnt <= '0;
                     ch_cnt  <= (ch_cnt == CW'(CHANNEL_NUM_OUT - 1)) ? '0 : ch_cnt + 1'b1;
                  end else begin
                     pix_cnt <= pix_cnt + 1'b1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   always_comb begin
      sc_word = scale_mem[ch_cnt];
      px_ext  = {{DATA_WIDTH{pxl_in[DATA_WIDTH-1]}}, pxl_in};
      sc_ext  = {{DATA_WIDTH{sc_word[DATA_WIDTH-1]}}, sc_word};
   end

   // Round-half-up, rescale, clamp to word range, then add bias with a second clamp.
   always_comb begin
      rounded = (s1_prod + RND) >>> FRAC_BITS;
      if (rounded > MAX_L)
         scaled = MAX_W;
      else if (rounded < MIN_L)
         scaled = MIN_W;
      else
         scaled = rounded[DATA_WIDTH-1:0];
      sum_ext = {scaled[DATA_WIDTH-1], scaled} + {s1_bias[DATA_WIDTH-1], s1_bias};
      if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])
         sat_sum = sum_ext[DATA_WIDTH] ? MIN_W : MAX_W;
      else
         sat_sum = sum_ext[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid  <= 1'b0;
         s1_prod   <= '0;
         s1_bias   <= '0;
         s2_valid  <= 1'b0;
         s2_sum    <= '0;
         valid_out <= 1'b0;
         pxl_out   <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_prod <= px_ext * sc_ext;
            s1_bias <= bias_mem[ch_cnt];
         end
         s2_valid <= s1_valid;
         if (s1_valid)
            s2_sum <= sat_sum;
         valid_out <= s2_valid;
         if (s2_valid)
            pxl_out <= s2_sum[DATA_WIDTH-1] ? '0 : s2_sum;
      end
   end

endmodule

// File: doc/conv_bn_relu_channel_out.md
Name: conv_bn_relu_channel_out

Overview:
- Post-processing stage directly downstream of the 3x3 conv layer (after its channel-in adder and output-align FIFO).
- Applies per-output-channel batch-norm (fixed-point scale and bias), then ReLU, to a channel-major pixel stream.
- Per-channel coefficients are loaded once after reset from the weight stream and held in an internal register file.
- The block is a 3-stage pipeline with no backpressure.

Parameters:
- DATA_WIDTH, 32, width of pixel, scale and bias words (signed two's complement fixed point).
- FRAC_BITS, 16, number of fractional bits in pixel, scale and bias.
- IMAGE_WIDTH, 32, image width in pixels.
- IMAGE_HEIGHT, 32, image height in pixels.
- CHANNEL_NUM_OUT, 128, number of output channels (number of coefficient pairs).
- Local parameter IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-low reset.
- valid_weight_in  input  1  coefficient word strobe.
- weight_in  input  DATA_WIDTH  coefficient word.
- valid_in  input  1  pixel strobe.
- pxl_in  input  DATA_WIDTH  pixel, channel-major order: IMAGE_SIZE pixels of ch0, then ch1, and so on.
- pxl_out  output  DATA_WIDTH  BN+ReLU result.
- valid_out  output  1  pxl_out qualifier.
- coef_ready  output  1  high once all coefficients are loaded.
- err_out  output  1  sticky: a pixel arrived before coef_ready.

Behaviour:
- Reset: asynchronous, asserted when reset=0.
  - All outputs are 0: pxl_out=0, valid_out=0, coef_ready=0, err_out=0.
  - State returns to LOAD; all counters clear; all pipeline valids clear.
  - Coefficient contents are don't-care.
  - Reset mid-frame discards in-flight data and requires a full coefficient reload.
- State LOAD:
  - Each valid_weight_in word is stored, alternating: scale[c], then bias[c], for c = 0..CHANNEL_NUM_OUT-1.
  - A word counter of width clog2(2*CHANNEL_NUM_OUT) tracks position.
  - On the cycle the 2*CHANNEL_NUM_OUT-th word is written: next state is RUN and coef_ready goes to 1 on the following cycle.
- State LOAD, pixel handling:
  - valid_in pixels are dropped and err_out is set to 1 (sticky until reset).
  - This includes a pixel arriving in the same cycle as the final bias word.
- State RUN, coefficient handling:
  - valid_weight_in is ignored.
  - Coefficients change only through reset.
- State RUN, pixel handling:
  - Each valid_in pixel is accepted.
  - pix_cnt (0..IMAGE_SIZE-1) increments per accepted pixel.
  - On pix_cnt wrap, ch_cnt (0..CHANNEL_NUM_OUT-1) increments.
  - On ch_cnt wrap from the last channel, ch_cnt returns to 0 (next frame); this is seamless, with no bubble needed.
  - Gaps in valid_in are allowed; counters hold while valid_in=0.
- Pipeline (valid_out follows the accepted valid_in by exactly 3 cycles):
  - S1: register prod = pxl_in * scale[ch_cnt], signed, 2*DATA_WIDTH bits.
  - S2: round prod by adding 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, saturate to DATA_WIDTH signed range, then add bias[ch_cnt] (bias registered alongside S1).
    - The sum is computed at DATA_WIDTH+1 bits and saturated to DATA_WIDTH.
    - Saturation limits: max = 2^(DATA_WIDTH-1)-1, min = -2^(DATA_WIDTH-1).
  - S3: ReLU: pxl_out = (sum < 0) ? 0 : sum.
  - valid_out = S3 valid.
- pxl_out holds its last value when valid_out=0.
- Coefficient read-out is synchronous; the coefficient index used is the ch_cnt value at acceptance.
- Back-to-back pixels produce back-to-back outputs, with 1 result per cycle sustained.

Test Plan:
- Identity: set IMAGE_WIDTH=2, IMAGE_HEIGHT=2, CHANNEL_NUM_OUT=2. Load scale 0x00010000 and bias 0 for both channels. Send pixels 0x00020000, 0xFFFF0000, 0x00008000, 0.
  - Required: outputs 0x00020000, 0, 0x00008000, 0.
  - Each output appears exactly 3 cycles after its input; coef_ready=1 on the cycle after the 4th word.
- Per-channel select: ch0 scale=2.0 (0x00020000), bias=0; ch1 scale=0.5 (0x00008000), bias=1.0 (0x00010000). Send 8 pixels of value 0x00010000.
  - Required: 4 outputs of 0x00020000, then 4 outputs of 0x00018000.
  - The counters then wrap, and the 9th pixel uses ch0 again.
- Saturation: scale=0x7FFFFFFF, pixel 0x7FFFFFFF, bias=0x7FFFFFFF.
  - Required: pxl_out=0x7FFFFFFF.
  - Same with pixel 0x80000000: pxl_out=0 (negative saturation followed by ReLU).
- Rounding: scale=0x00018000 (1.5), pixel=0x00000001.
  - Required: pxl_out=0x00000002 (1.5 LSB rounds up).
- Early pixel: send valid_in during LOAD, including the final-bias cycle.
  - Required: no valid_out for these pixels; err_out=1 and remains 1.
  - Pixels sent after coef_ready still process correctly starting from ch0.
- Async reset: drop reset mid-frame, between clock edges.
  - Required: valid_out and coef_ready go to 0 immediately; no outputs appear after release until a full reload is done.
  - Weight words sent in RUN before the reset must have had no effect.
